// File: rtl/groestl_permutation_q_iter.sv
// groestl_permutation_q_iter: iterative Groestl-1024 Q permutation.
// One full Q round per clock; valid/ready handshake on both sides.
module groestl_permutation_q_iter #(
  parameter int ROUNDS = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1023:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  // row rotation amounts, row 0 in the MSBs
  localparam logic [31:0] SHQ = {
    4'd1, 4'd3, 4'd5, 4'd11,
    4'd0, 4'd2, 4'd4, 4'd6
  };

  // circulant MixBytes coefficients b0..b7
  localparam logic [23:0] MB = {
    3'd2, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd3, 3'd5, 3'd7
  };

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t        state_q, state_d;
  logic [3:0]    r_q, r_d;
  logic [1023:0] st_q, st_d, rnd;
  logic [7:0]    sb [8][16];
  logic [7:0]    sh [8][16];

  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    return SBOX[2047 - 8 * int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // coefficients never exceed 7, so three partial products suffice
  function automatic logic [7:0] mulb(
    input logic [7:0] a,
    input logic [2:0] b
  );
    logic [7:0] a2, a4;
    a2 = xt(a);
    a4 = xt(a2);
    return (b[0] ? a  : 8'h00)
         ^ (b[1] ? a2 : 8'h00)
         ^ (b[2] ? a4 : 8'h00);
  endfunction

  // AddRoundConstantQ followed by SubBytes on every byte
  always_comb begin
    logic [7:0] t;
    t = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) begin
        t = st_q[1023 - 64 * j - 8 * i -: 8] ^ 8'hff;
        if (i == 7)
          t = t ^ {4'(j), 4'h0} ^ {4'h0, r_q};
        sb[i][j] = sbox(t);
      end
    end
  end

  // ShiftBytesQ: row i rotates left by its shift amount
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) begin
        sh[i][j] = sb[i][(j + int'(SHQ[31 - 4 * i -: 4])) % 16];
      end
    end
  end

  // MixBytes: each column times the circulant matrix
  always_comb begin
    logic [7:0] acc;
    acc = 8'h00;
    rnd = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 8; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 8; k++)
          acc = acc ^ mulb(sh[(i + k) % 8][j], MB[23 - 3 * k -: 3]);
        rnd[1023 - 64 * j - 8 * i -: 8] = acc;
      end
    end
  end

  // next-state: load, iterate rounds, hold result until taken
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = in_data;
          r_d     = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d = rnd;
        r_d  = r_q + 4'd1;
        if (r_q == LAST)
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, round counter and permutation state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= 4'd0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      st_q    <= st_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = st_q;

endmodule

// File: tb/tb_groestl_permutation_q_iter.sv
// tb_groestl_permutation_q_iter: directed and streamed checks of the
// iterative Q permutation against a byte-matrix reference model.
module tb_groestl_permutation_q_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready;
  logic          out_valid, out_ready;
  logic [1023:0] in_data, out_data;

  logic          v1, ir1, ov1, or1;
  logic [1023:0] d1, q1;

  groestl_permutation_q_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  groestl_permutation_q_iter #(.ROUNDS(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (v1),
    .in_ready  (ir1),
    .in_data   (d1),
    .out_valid (ov1),
    .out_ready (or1),
    .out_data  (q1)
  );

  localparam int         SHQ_TB [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
  localparam logic [7:0] BQ [8] = '{8'h02, 8'h02, 8'h03, 8'h04,
                                    8'h05, 8'h03, 8'h05, 8'h07};

  int            n_chk = 0;
  int            n_pass = 0;
  logic [7:0]    sb_tab [256];
  logic [1023:0] exp_q [$];

  task automatic chk(input string tag,
                     input logic [1023:0] got,
                     input logic [1023:0] exp);
    int w;
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      w = 0;
      for (int k = 15; k >= 0; k--)
        if (got[1023 - 64 * k -: 64] !== exp[1023 - 64 * k -: 64]) w = k;
      $display("FAIL %s: got %h expected %h (64-bit word %0d)",
               tag, got[1023 - 64 * w -: 64], exp[1023 - 64 * w -: 64], w);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // AES S-box from the field inverse and the affine map
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
      sb_tab[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [1023:0] q_model(input logic [1023:0] x,
                                            input int rounds);
    logic [7:0]    m [8][16];
    logic [7:0]    t [8][16];
    logic [7:0]    acc;
    logic [1023:0] y;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 8; i++)
        m[i][j] = x[1023 - 64 * j - 8 * i -: 8];
    for (int r = 0; r < rounds; r++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++) begin
          m[i][j] = m[i][j] ^ 8'hff;
          if (i == 7) m[i][j] = m[i][j] ^ 8'(16 * j) ^ 8'(r);
          m[i][j] = sb_tab[m[i][j]];
        end
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++)
          t[i][j] = m[i][(j + SHQ_TB[i]) % 16];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++) begin
          acc = 8'h00;
          for (int k = 0; k < 8; k++)
            acc = acc ^ gm(BQ[k], t[(i + k) % 8][j]);
          m[i][j] = acc;
        end
    end
    y = '0;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 8; i++)
        y[1023 - 64 * j - 8 * i -: 8] = m[i][j];
    return y;
  endfunction

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[32 * w +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int            lat, seen, got, b, cyc;
    int            acc_cyc [$];
    logic [1023:0] blk, held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    v1        = 1'b0;
    d1        = '0;
    or1       = 1'b0;
    build_sbox();

    // reset values, observed between edges
    #12;
    chk("rst in_ready", 1024'(in_ready), 1024'(1));
    chk("rst out_valid", 1024'(out_valid), 1024'(0));
    chk("rst out_data", out_data, '0);
    chk("rst1 in_ready", 1024'(ir1), 1024'(1));

    // Q(0), 14 rounds, accepted on the first edge after reset drops
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    tick();
    in_valid = 1'b0;
    chk("accept after reset", 1024'(in_ready), 1024'(0));
    wait_ov(lat);
    chk("latency 14", 1024'(lat), 1024'(14));
    chk("q0 data", out_data, q_model('0, 14));
    tick();
    chk("q0 released", 1024'(in_ready), 1024'(1));

    // single-round instance: hand-derived columns plus model
    or1 = 1'b1;
    v1  = 1'b1;
    d1  = '0;
    tick();
    v1  = 1'b0;
    lat = 0;
    while (!ov1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency 1", 1024'(lat), 1024'(1));
    chk("r1 col0", 1024'(q1[1023 -: 64]), 1024'(64'h6fee76ee2376bbbb));
    chk("r1 col10", 1024'(q1[383 -: 64]), 1024'({8{8'h3a}}));
    chk("r1 model", q1, q_model('0, 1));
    tick();
    blk = rnd1024();
    d1  = blk;
    v1  = 1'b1;
    tick();
    v1  = 1'b0;
    d1  = '0;
    tick();
    chk("r1 random", q1, q_model(blk, 1));

    // back-pressure: output held 20 cycles, inputs ignored
    tick();
    out_ready = 1'b0;
    blk       = rnd1024();
    in_data   = blk;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(lat);
    chk("bp latency", 1024'(lat), 1024'(14));
    chk("bp data", out_data, q_model(blk, 14));
    held = out_data;
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      in_data  = ~blk;
      tick();
      chk("bp hold data", out_data, held);
      chk("bp in_ready", 1024'(in_ready), 1024'(0));
      chk("bp out_valid", 1024'(out_valid), 1024'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp done ready", 1024'(in_ready), 1024'(1));
    chk("bp done valid", 1024'(out_valid), 1024'(0));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("bp no ghost", 1024'(seen), 1024'(0));

    // asynchronous reset in the middle of a run
    blk      = rnd1024();
    in_data  = blk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("mid run busy", 1024'(in_ready), 1024'(0));
    #3 reset = 1'b1;
    #1;
    chk("async in_ready", 1024'(in_ready), 1024'(1));
    chk("async out_valid", 1024'(out_valid), 1024'(0));
    chk("async out_data", out_data, '0);
    tick();
    #2 reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (out_valid || !in_ready) seen++;
    end
    chk("abandoned block", 1024'(seen), 1024'(0));

    // peak throughput with both sides always willing
    exp_q.delete();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = rnd1024();
    for (int c = 0; c < 70; c++) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("tp extra", 1024'(1), 1024'(0));
        else chk("tp data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(q_model(in_data, 14));
        acc_cyc.push_back(c);
      end
      tick();
      if (!in_ready) in_data = rnd1024();
    end
    in_valid = 1'b0;
    chk("tp accepts", 1024'(acc_cyc.size()), 1024'(5));
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("tp spacing", 1024'(acc_cyc[k] - acc_cyc[k - 1]), 1024'(16));
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
      if (out_valid && out_ready)
        chk("tp drain", out_data, exp_q.pop_front());
      tick();
    end
    chk("tp leftover", 1024'(exp_q.size()), 1024'(0));

    // 100 random blocks, random handshakes on both sides
    exp_q.delete();
    got = 0;
    fork
      begin
        logic [1023:0] nb;
        nb  = rnd1024();
        b   = 0;
        cyc = 0;
        while (b < 100 && cyc < 20000) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = nb;
          if (in_valid && in_ready) begin
            exp_q.push_back(q_model(nb, 14));
            b++;
            nb = rnd1024();
          end
          tick();
          cyc++;
        end
        in_valid = 1'b0;
      end
      begin
        int mc;
        mc = 0;
        while (got < 100 && mc < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("stream extra", 1024'(1), 1024'(0));
            else chk("stream data", out_data, exp_q.pop_front());
            got++;
          end
          tick();
          mc++;
        end
      end
    join
    chk("stream count", 1024'(got), 1024'(100));
    chk("stream leftover", 1024'(exp_q.size()), 1024'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
